timer_reload_ctrl: RTL and testbench

TIMER_RELOAD_CTRL -- requirements
Module: timer_reload_ctrl

---
 rtl/timer_pkg.sv | 37 +++
 rtl/timer_regs.sv | 91 +++++++++
 rtl/timer_reload_ctrl.sv | 115 +++++++++++
 tb/tb_timer_reload_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the reload timer controller: register map,
// CTRL/STATUS bit positions and the controller FSM state encoding.
package timer_pkg;

  // Register addresses seen on the CPU port
  localparam logic [1:0] ADDR_PRESET = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_DIR = 1;
  localparam int CTRL_AR  = 2;
  localparam int CTRL_IE  = 3;

  // STATUS bit positions
  localparam int STAT_DONE    = 0;
  localparam int STAT_RUNNING = 1;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  // Decoded CTRL register contents
  typedef struct packed {
    logic ie;
    logic ar;
    logic dir;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/timer_regs.sv
// CPU-visible register file of the reload timer: PRESET, CTRL, sticky
// STATUS.done and the combinational read-back mux (COUNT reads the live
// counter value and ignores writes).
module timer_regs
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [CNT_W-1:0] wdata,
  input  logic [CNT_W-1:0] cnt,
  input  logic             running,
  input  logic             done_set,
  input  logic             en_clr,
  output logic [CNT_W-1:0] rdata,
  output logic [CNT_W-1:0] preset,
  output ctrl_t            ctrl,
  output logic             done,
  output logic             en_off_wr
);

  logic wr_preset;
  logic wr_ctrl;
  logic wr_status;
  logic done_clr;

  assign wr_preset = wr_en && (addr == ADDR_PRESET);
  assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
  assign wr_status = wr_en && (addr == ADDR_STATUS);
  assign done_clr  = wr_status && wdata[STAT_DONE];

  // A CPU write that turns en off aborts the controller back to IDLE.
  assign en_off_wr = wr_ctrl && !wdata[CTRL_EN];

  // Register updates: CPU writes, hardware en clear on a halting terminal
  // count, and sticky done where a hardware set beats a write-1-to-clear.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; the later en_clr assignment overrides the
  // CPU-written en bit within the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      preset <= '0;
      ctrl   <= '0;
      done   <= 1'b0;
    end else begin
      if (wr_preset) begin
        preset <= wdata;
      end
      if (wr_ctrl) begin
        ctrl.en  <= wdata[CTRL_EN];
        ctrl.dir <= wdata[CTRL_DIR];
        ctrl.ar  <= wdata[CTRL_AR];
        ctrl.ie  <= wdata[CTRL_IE];
      end
      if (en_clr) begin
        ctrl.en <= 1'b0;
      end
      if (done_set) begin
        done <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
    end
  end

  // Read-back mux; unused bits of CTRL and STATUS read as zero.
  // NOTE: rdata gets a full default before the case so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_PRESET: rdata = preset;
      ADDR_CTRL: begin
        rdata[CTRL_EN]  = ctrl.en;
        rdata[CTRL_DIR] = ctrl.dir;
        rdata[CTRL_AR]  = ctrl.ar;
        rdata[CTRL_IE]  = ctrl.ie;
      end
      ADDR_STATUS: begin
        rdata[STAT_DONE]    = done;
        rdata[STAT_RUNNING] = running;
      end
      ADDR_COUNT: rdata = cnt;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/timer_reload_ctrl.sv
// Reload timer controller: sequences an external up/down counter through
// preload, run, terminal-count and reload/halt using only the s, Load,
// PData, cnt and Rc signals. Load depends on state alone, so there is no
// combinational path from Rc to Load.
module timer_reload_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] rdata,
  output logic             s,
  output logic             Load,
  output logic [CNT_W-1:0] PData,
  input  logic [CNT_W-1:0] cnt,
  input  logic             Rc,
  output logic             irq
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] cnt_cap;
  ctrl_t            ctrl;
  logic             done;
  logic             en_off_wr;
  logic             running;
  logic             terminal;
  logic             en_clr;

  // A terminal count only counts while running and not being aborted by a
  // same-edge write of en=0 (an abort never sets done).
  assign running  = (state == ST_RUN);
  assign terminal = running && Rc && !en_off_wr;
  assign en_clr   = terminal && !ctrl.ar;

  assign s   = ctrl.dir;
  assign irq = done && ctrl.ie;

  timer_regs #(
    .CNT_W(CNT_W)
  ) u_regs (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .addr     (addr),
    .wdata    (wdata),
    .cnt      (cnt),
    .running  (running),
    .done_set (terminal),
    .en_clr   (en_clr),
    .rdata    (rdata),
    .preset   (preset),
    .ctrl     (ctrl),
    .done     (done),
    .en_off_wr(en_off_wr)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the counter value at the terminal edge so HALT can freeze it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_cap <= '0;
    end else if (terminal) begin
      cnt_cap <= cnt;
    end
  end

  // Next-state logic; an en=0 write returns to IDLE from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ctrl.en) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN: begin
        if (terminal) begin
          state_nxt = ctrl.ar ? ST_LOAD : ST_HALT;
        end
      end
      ST_HALT: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (en_off_wr) begin
      state_nxt = ST_IDLE;
    end
  end

  // Counter control outputs: hold PRESET everywhere except RUN (count)
  // and HALT (hold the captured terminal value).
  always_comb begin
    Load  = 1'b1;
    PData = preset;
    case (state)
      ST_RUN:  Load  = 1'b0;
      ST_HALT: PData = cnt_cap;
      default: begin
        Load  = 1'b1;
        PData = preset;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_reload_ctrl.sv
// Self-checking bench for timer_reload_ctrl with a behavioural up/down
// counter attached to s/Load/PData/cnt/Rc.
module tb_timer_reload_ctrl;
  import timer_pkg::*;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        s;
  logic        Load;
  logic [31:0] PData;
  logic [31:0] cnt;
  logic        Rc;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_reload_ctrl #(
    .CNT_W(32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .wr_en(wr_en),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .s    (s),
    .Load (Load),
    .PData(PData),
    .cnt  (cnt),
    .Rc   (Rc),
    .irq  (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter attached to the controller
  always @(posedge clk) begin
    if (Load)   cnt <= PData;
    else if (s) cnt <= cnt + 32'd1;
    else        cnt <= cnt - 32'd1;
  end
  assign Rc = s ? (&cnt) : (cnt == 32'd0);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rdata;
    logic        exp_s;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_state(input string name, input state_t exp);
    check(name, 32'(dut.state), 32'(exp));
  endtask

  logic [31:0] v;

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    addr  = 2'd0;
    wdata = '0;

    // Register access vectors, applied from reset
    vecs[0] = '{1'b1, ADDR_PRESET, 32'h1234_5678, ADDR_PRESET, 32'h1234_5678, 1'b0, 1'b0};
    vecs[1] = '{1'b1, ADDR_CTRL,   32'hFFFF_FFFA, ADDR_CTRL,   32'h0000_000A, 1'b1, 1'b0};
    vecs[2] = '{1'b1, ADDR_COUNT,  32'hDEAD_BEEF, ADDR_COUNT,  32'h1234_5678, 1'b1, 1'b0};
    vecs[3] = '{1'b1, ADDR_STATUS, 32'h0000_0003, ADDR_STATUS, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, ADDR_PRESET, 32'h0000_0000, ADDR_PRESET, 32'h1234_5678, 1'b1, 1'b0};
    vecs[5] = '{1'b1, ADDR_CTRL,   32'h0000_0004, ADDR_CTRL,   32'h0000_0004, 1'b0, 1'b0};
    vecs[6] = '{1'b1, ADDR_PRESET, 32'hFFFF_FFFF, ADDR_COUNT,  32'h1234_5678, 1'b0, 1'b0};
    vecs[7] = '{1'b0, ADDR_PRESET, 32'h0000_0000, ADDR_COUNT,  32'hFFFF_FFFF, 1'b0, 1'b0};

    // Reset state
    do_reset();
    check("rst Load", 32'(Load), 32'd1);
    check("rst PData", PData, 32'd0);
    check("rst s", 32'(s), 32'd0);
    check("rst irq", 32'(irq), 32'd0);
    rd(ADDR_CTRL, v);   check("rst ctrl", v, 32'd0);
    rd(ADDR_STATUS, v); check("rst status", v, 32'd0);
    check_state("rst state", ST_IDLE);

    // Table-driven register accesses
    for (int i = 0; i < 8; i++) begin
      wr_en = vecs[i].wr;
      addr  = vecs[i].addr;
      wdata = vecs[i].wdata;
      tick();
      wr_en = 1'b0;
      rd(vecs[i].rd_addr, v);
      check($sformatf("vec%0d rdata", i), v, vecs[i].exp_rdata);
      check($sformatf("vec%0d s", i), 32'(s), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Down count from 5, no auto-reload
    do_reset();
    cpu_write(ADDR_PRESET, 32'd5);
    cpu_write(ADDR_CTRL, 32'h1);
    check("dn idle cnt", cnt, 32'd5);
    tick();
    check_state("dn load state", ST_LOAD);
    check("dn load Load", 32'(Load), 32'd1);
    check("dn load PData", PData, 32'd5);
    tick();
    check_state("dn run state", ST_RUN);
    check("dn run Load", 32'(Load), 32'd0);
    check("dn run cnt", cnt, 32'd5);
    rd(ADDR_STATUS, v); check("dn running", v, 32'd2);
    for (int k = 4; k >= 0; k--) begin
      tick();
      check($sformatf("dn cnt%0d", k), cnt, 32'(k));
    end
    tick();
    check_state("dn halt state", ST_HALT);
    rd(ADDR_STATUS, v); check("dn done", v, 32'd1);
    check("dn halt Load", 32'(Load), 32'd1);
    check("dn halt PData", PData, 32'd0);
    tick();
    check_state("dn idle state", ST_IDLE);
    check("dn frozen cnt", cnt, 32'd0);
    rd(ADDR_CTRL, v); check("dn en cleared", v, 32'd0);

    // Up count with auto-reload, three periods
    do_reset();
    cpu_write(ADDR_PRESET, 32'hFFFF_FFFC);
    cpu_write(ADDR_CTRL, 32'h7);
    tick();
    tick();
    check("ar first cnt", cnt, 32'hFFFF_FFFC);
    check("ar s", 32'(s), 32'd1);
    for (int p = 0; p < 3; p++) begin
      cpu_write(ADDR_STATUS, 32'h1);
      check($sformatf("ar p%0d cnt d", p), cnt, 32'hFFFF_FFFD);
      rd(ADDR_STATUS, v); check($sformatf("ar p%0d done clr", p), v, 32'd2);
      tick();
      tick();
      check($sformatf("ar p%0d cnt ff", p), cnt, 32'hFFFF_FFFF);
      check($sformatf("ar p%0d Rc", p), 32'(Rc), 32'd1);
      tick();
      check_state($sformatf("ar p%0d load", p), ST_LOAD);
      rd(ADDR_STATUS, v); check($sformatf("ar p%0d done", p), v, 32'd1);
      check($sformatf("ar p%0d Load", p), 32'(Load), 32'd1);
      check($sformatf("ar p%0d PData", p), PData, 32'hFFFF_FFFC);
      tick();
      check($sformatf("ar p%0d reload", p), cnt, 32'hFFFF_FFFC);
    end
    cpu_write(ADDR_CTRL, 32'h0);
    check_state("ar stop", ST_IDLE);

    // Interrupt, clear, and clear coinciding with terminal count
    do_reset();
    cpu_write(ADDR_PRESET, 32'd2);
    cpu_write(ADDR_CTRL, 32'h9);
    repeat (5) tick();
    check_state("irq halt", ST_HALT);
    check("irq set", 32'(irq), 32'd1);
    cpu_write(ADDR_STATUS, 32'h1);
    check("irq cleared", 32'(irq), 32'd0);
    cpu_write(ADDR_CTRL, 32'h9);
    repeat (4) tick();
    check("irq2 cnt0", cnt, 32'd0);
    check("irq2 Rc", 32'(Rc), 32'd1);
    cpu_write(ADDR_STATUS, 32'h1);
    rd(ADDR_STATUS, v); check("set beats clear", v, 32'd1);
    check("irq2 set", 32'(irq), 32'd1);

    // en cleared mid-run at cnt=3
    do_reset();
    cpu_write(ADDR_PRESET, 32'd10);
    cpu_write(ADDR_CTRL, 32'h1);
    tick();
    tick();
    repeat (7) tick();
    check("abort cnt3", cnt, 32'd3);
    cpu_write(ADDR_CTRL, 32'h0);
    check_state("abort idle", ST_IDLE);
    check("abort Load", 32'(Load), 32'd1);
    check("abort PData", PData, 32'd10);
    rd(ADDR_STATUS, v); check("abort no done", v, 32'd0);
    tick();
    check("abort reload", cnt, 32'd10);

    // Reset in the middle of a run
    do_reset();
    cpu_write(ADDR_PRESET, 32'd10);
    cpu_write(ADDR_CTRL, 32'hB);
    repeat (4) tick();
    check("mrst running cnt", cnt, 32'd12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst Load", 32'(Load), 32'd1);
    check("mrst PData", PData, 32'd0);
    check("mrst s", 32'(s), 32'd0);
    check("mrst irq", 32'(irq), 32'd0);
    rd(ADDR_CTRL, v);   check("mrst ctrl", v, 32'd0);
    rd(ADDR_STATUS, v); check("mrst status", v, 32'd0);
    check_state("mrst state", ST_IDLE);

    // PRESET equal to the terminal value: one run cycle
    do_reset();
    cpu_write(ADDR_PRESET, 32'd0);
    cpu_write(ADDR_CTRL, 32'h1);
    tick();
    tick();
    check_state("zero run", ST_RUN);
    check("zero Rc", 32'(Rc), 32'd1);
    tick();
    check_state("zero halt", ST_HALT);
    rd(ADDR_STATUS, v); check("zero done", v, 32'd1);
    check("zero PData", PData, 32'd0);
    tick();
    check_state("zero idle", ST_IDLE);
    check("zero cnt a", cnt, 32'd0);
    tick();
    check("zero cnt b", cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
